// File: rtl/kmeans_mem_sched_if.sv
// rtl/kmeans_mem_sched_if.sv - bus bundle between the k-means memory scheduler and its environment
// Purpose: groups the input stream, the single-port SRAM port, the point stream
//          and the iteration control/status lines of kmeans_mem_sched.
// Ports (master = scheduler side):
//   in_valid/in_data            header + point words into the scheduler
//   mem_ce/mem_we/mem_addr/mem_wdata/mem_rdata   SRAM port
//   pt_valid/pt_data/pt_last/pt_ready            point stream to the datapath
//   sweep_start/iter_idx/dp_done/busy/done/err   iteration control and status
interface kmeans_mem_sched_if #(
  parameter int DW = 16,
  parameter int AW = 12
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          pt_valid;
  logic [DW-1:0] pt_data;
  logic          pt_last;
  logic          pt_ready;
  logic          sweep_start;
  logic [7:0]    iter_idx;
  logic          dp_done;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  in_valid, in_data, mem_rdata, pt_ready, dp_done,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    output pt_valid, pt_data, pt_last, sweep_start, iter_idx, busy, done, err
  );

  modport slave (
    output in_valid, in_data, mem_rdata, pt_ready, dp_done,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    input  pt_valid, pt_data, pt_last, sweep_start, iter_idx, busy, done, err
  );
endinterface

// File: rtl/kmeans_mem_sched.sv
// rtl/kmeans_mem_sched.sv - point-memory scheduler for the k-means engine
// Purpose: parses a two-word header (point count n, iteration count), loads n
//          points into a single-port SRAM, then replays them to the datapath
//          once per iteration through a two-entry buffer, waiting for the
//          datapath's end-of-iteration pulse between sweeps.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  kmeans_mem_sched_if.master (stream in, SRAM port, point stream, status)
module kmeans_mem_sched #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  kmeans_mem_sched_if.master    bus
);

  typedef enum logic [2:0] {IDLE, HDR1, LOAD, SWEEP, WAIT_DP, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW:0]   n_q;
  logic [AW:0]   rptr_q;
  logic [AW-1:0] wcnt_q;
  logic [7:0]    iter_q;
  logic [7:0]    iter_idx_q;
  logic          err_q;
  logic          sweep_start_q;
  logic          rd_inflight_q;
  logic          rd_last_q;
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic [1:0]    fifo_cnt_q;

  logic          hdr_bad;
  logic          pt_valid_w;
  logic          pop;
  logic          last_pop;
  logic          rd_issue;
  logic [2:0]    occ;
  logic          sweep_entry;
  logic          final_iter;

  // n must lie in 1..2^AW; anything else is rejected without leaving IDLE.
  assign hdr_bad    = (bus.in_data == '0) || (32'(bus.in_data) > (32'd1 << AW));
  assign pt_valid_w = (fifo_cnt_q != 2'd0);
  assign pop        = pt_valid_w & bus.pt_ready;
  assign last_pop   = pop & fifo_last_q[0];
  // Buffered entries plus the read still in flight, less what leaves this
  // cycle, must stay below 2 so a returning read always finds a free slot.
  assign occ        = 3'(fifo_cnt_q) + 3'(rd_inflight_q);
  assign rd_issue   = (state == SWEEP) && (rptr_q < n_q) && ((occ - 3'(pop)) < 3'd2);
  assign final_iter = (iter_idx_q == iter_q - 8'd1);
  assign sweep_entry = (state_nxt == SWEEP) && (state != SWEEP);

  always_comb begin
    state_nxt     = state;
    bus.mem_ce    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE:    if (bus.in_valid && !hdr_bad) state_nxt = HDR1;
      HDR1:    if (bus.in_valid) state_nxt = LOAD;
      LOAD: begin
        bus.mem_ce    = bus.in_valid;
        bus.mem_we    = bus.in_valid;
        bus.mem_addr  = wcnt_q;
        bus.mem_wdata = bus.in_data;
        if (bus.in_valid && ({1'b0, wcnt_q} == n_q - (AW+1)'(1))) state_nxt = SWEEP;
      end
      SWEEP: begin
        bus.mem_ce   = rd_issue;
        bus.mem_addr = rptr_q[AW-1:0];
        if (last_pop) state_nxt = WAIT_DP;
      end
      WAIT_DP: if (bus.dp_done) state_nxt = final_iter ? DONE : SWEEP;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      n_q            <= '0;
      rptr_q         <= '0;
      wcnt_q         <= '0;
      iter_q         <= '0;
      iter_idx_q     <= '0;
      err_q          <= 1'b0;
      sweep_start_q  <= 1'b0;
      rd_inflight_q  <= 1'b0;
      rd_last_q      <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      state         <= state_nxt;
      err_q         <= (state == IDLE) && bus.in_valid && hdr_bad;
      sweep_start_q <= sweep_entry;

      if (state == IDLE && bus.in_valid) n_q <= bus.in_data[AW:0];
      if (state == HDR1 && bus.in_valid) begin
        iter_q <= (bus.in_data[7:0] == 8'd0) ? 8'd1 : bus.in_data[7:0];
        wcnt_q <= '0;
      end
      if (state == LOAD && bus.in_valid) wcnt_q <= wcnt_q + AW'(1);

      if (sweep_entry) rptr_q <= '0;
      else if (rd_issue) rptr_q <= rptr_q + (AW+1)'(1);

      if (state == WAIT_DP && bus.dp_done && !final_iter) iter_idx_q <= iter_idx_q + 8'd1;
      else if (state == DONE) iter_idx_q <= '0;

      // SRAM returns data one cycle after the read; tag it with its last flag.
      rd_inflight_q <= rd_issue;
      rd_last_q     <= (rptr_q == n_q - (AW+1)'(1));

      case ({rd_inflight_q, pop})
        2'b10: begin
          if (fifo_cnt_q == 2'd0) begin
            fifo_data_q[0] <= bus.mem_rdata;
            fifo_last_q[0] <= rd_last_q;
          end else begin
            fifo_data_q[1] <= bus.mem_rdata;
            fifo_last_q[1] <= rd_last_q;
          end
          fifo_cnt_q <= fifo_cnt_q + 2'd1;
        end
        2'b01: begin
          fifo_data_q[0] <= fifo_data_q[1];
          fifo_last_q[0] <= fifo_last_q[1];
          fifo_cnt_q     <= fifo_cnt_q - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            fifo_data_q[0] <= bus.mem_rdata;
            fifo_last_q[0] <= rd_last_q;
          end else begin
            fifo_data_q[0] <= fifo_data_q[1];
            fifo_last_q[0] <= fifo_last_q[1];
            fifo_data_q[1] <= bus.mem_rdata;
            fifo_last_q[1] <= rd_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pt_valid    = pt_valid_w;
  assign bus.pt_data     = pt_valid_w ? fifo_data_q[0] : '0;
  assign bus.pt_last     = pt_valid_w & fifo_last_q[0];
  assign bus.sweep_start = sweep_start_q;
  assign bus.iter_idx    = iter_idx_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_kmeans_mem_sched.sv
// tb/tb_kmeans_mem_sched.sv - self-checking bench for kmeans_mem_sched
module tb_kmeans_mem_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kmeans_mem_sched_if #(.DW(16), .AW(12)) bus ();
  kmeans_mem_sched #(.DW(16), .AW(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  // SRAM model: synchronous write, read data valid the cycle after the read.
  logic [15:0] sram [4096];
  always @(posedge clk) begin
    if (bus.mem_ce === 1'b1) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata      <= sram[bus.mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;
  logic [15:0] pts [4096];

  // Monitor state, sampled on the falling edge.
  int cyc = 0, sweep_cyc = 0, done_cnt = 0, last_cnt = 0;
  int rd_cnt = 0, hs_cnt = 0, stall_viol = 0, out_viol = 0;
  bit first_seen = 1'b0, prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [15:0] got_data [$];
  bit          got_last [$];
  int          ss_iter [$];
  int          fv_delay [$];
  int          sw_len [$];
  logic [11:0] wr_addr [$];
  logic [15:0] wr_data [$];

  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
      rd_cnt = hs_cnt;
    end else begin
      if (bus.sweep_start) begin
        sweep_cyc = cyc;
        ss_iter.push_back(int'(bus.iter_idx));
        first_seen = 1'b0;
      end
      if (bus.pt_valid && !first_seen) begin
        fv_delay.push_back(cyc - sweep_cyc);
        first_seen = 1'b1;
      end
      if (prev_stall && !(bus.pt_valid && bus.pt_data === prev_data && bus.pt_last === prev_last))
        stall_viol++;
      prev_stall = bus.pt_valid && !bus.pt_ready;
      prev_data  = bus.pt_data;
      prev_last  = bus.pt_last;
      if (bus.mem_ce && bus.mem_we) begin
        wr_addr.push_back(bus.mem_addr);
        wr_data.push_back(bus.mem_wdata);
      end
      if (bus.mem_ce && !bus.mem_we) rd_cnt++;
      if (bus.pt_valid && bus.pt_ready) begin
        got_data.push_back(bus.pt_data);
        got_last.push_back(bus.pt_last);
        hs_cnt++;
        if (bus.pt_last) begin
          sw_len.push_back(cyc - sweep_cyc);
          last_cnt++;
        end
      end
      if (rd_cnt - hs_cnt > 2) out_viol++;
      if (bus.done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string nm);
    check({nm, " pt_valid"},    32'(bus.pt_valid), 0);
    check({nm, " pt_data"},     32'(bus.pt_data), 0);
    check({nm, " pt_last"},     32'(bus.pt_last), 0);
    check({nm, " mem_ce"},      32'(bus.mem_ce), 0);
    check({nm, " mem_we"},      32'(bus.mem_we), 0);
    check({nm, " mem_addr"},    32'(bus.mem_addr), 0);
    check({nm, " mem_wdata"},   32'(bus.mem_wdata), 0);
    check({nm, " busy"},        32'(bus.busy), 0);
    check({nm, " done"},        32'(bus.done), 0);
    check({nm, " err"},         32'(bus.err), 0);
    check({nm, " sweep_start"}, 32'(bus.sweep_start), 0);
    check({nm, " iter_idx"},    32'(bus.iter_idx), 0);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic send_word(input logic [15:0] d, input bit noise);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.dp_done  = noise ? 1'($urandom % 2) : 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.dp_done  = 1'b0;
  endtask

  task automatic load_job(input int n, input int iw, input bit gaps, input bit noise);
    send_word(16'(n), noise);
    send_word(16'(iw), noise);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.dp_done = noise;
        @(posedge clk); #1;
        bus.dp_done = 1'b0;
      end
      send_word(pts[i], noise);
    end
  endtask

  task automatic bad_word(input logic [15:0] w, input string nm);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({nm, " err pulse"}, 32'(bus.err), 1);
    check({nm, " busy"},      32'(bus.busy), 0);
    @(posedge clk); #1;
    check({nm, " err clear"}, 32'(bus.err), 0);
    check({nm, " still idle"}, 32'(bus.busy), 0);
  endtask

  // mode: 0 = ready always high, 1 = pattern 1,0,0,1,0,1, 2 = random ready.
  task automatic run_job(input int n, input int iw, input int mode, input bit noise, input string nm);
    int hs0, ss0, dn0, wr0, sw0, fv0, cycles, cd, pat, its, mism, lastseen, idx, bound;
    logic [5:0] bp_pat;
    bp_pat = 6'b101001;
    its = (iw % 256 == 0) ? 1 : iw % 256;
    hs0 = got_data.size(); ss0 = ss_iter.size(); dn0 = done_cnt;
    wr0 = wr_addr.size(); sw0 = sw_len.size(); fv0 = fv_delay.size();
    load_job(n, iw, mode == 2, noise);
    cycles = 0; cd = 0; pat = 0; lastseen = last_cnt;
    bound = its * (n * 6 + 50) + 100;
    while (done_cnt == dn0 && cycles < bound) begin
      case (mode)
        0:       bus.pt_ready = 1'b1;
        1:       bus.pt_ready = bp_pat[pat % 6];
        default: bus.pt_ready = 1'($urandom % 2);
      endcase
      pat++;
      bus.dp_done = 1'b0;
      if (last_cnt != lastseen) begin
        lastseen = last_cnt;
        cd = 3;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) bus.dp_done = 1'b1;
      end
      bus.in_valid = noise ? 1'($urandom % 2) : 1'b0;
      bus.in_data  = 16'($urandom);
      @(posedge clk); #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
    bus.dp_done  = 1'b0;
    bus.pt_ready = 1'b0;
    check({nm, " done pulses"}, done_cnt - dn0, 1);
    check({nm, " busy after done"}, 32'(bus.busy), 0);
    check({nm, " handshakes"}, got_data.size() - hs0, n * its);
    mism = 0;
    for (int it = 0; it < its; it++)
      for (int i = 0; i < n; i++) begin
        idx = hs0 + it * n + i;
        if (idx >= got_data.size()) mism++;
        else if (got_data[idx] !== pts[i] || got_last[idx] !== (i == n - 1)) mism++;
      end
    check({nm, " stream mismatches"}, mism, 0);
    check({nm, " sweep_start count"}, ss_iter.size() - ss0, its);
    mism = 0;
    for (int k = ss0; k < ss_iter.size(); k++) if (ss_iter[k] != k - ss0) mism++;
    check({nm, " iter_idx sequence"}, mism, 0);
    check({nm, " write count"}, wr_addr.size() - wr0, n);
    mism = 0;
    for (int k = wr0; k < wr_addr.size(); k++)
      if (int'(wr_addr[k]) != k - wr0 || (k - wr0 < n && wr_data[k] !== pts[k - wr0])) mism++;
    check({nm, " write addr/data"}, mism, 0);
    mism = 0;
    for (int k = fv0; k < fv_delay.size(); k++) if (fv_delay[k] != 2) mism++;
    check({nm, " first valid latency"}, mism, 0);
    if (mode == 0) begin
      mism = 0;
      for (int k = sw0; k < sw_len.size(); k++) if (sw_len[k] != n + 1) mism++;
      check({nm, " sweep length"}, mism, 0);
    end
    check({nm, " stall stability"}, stall_viol, 0);
    check({nm, " outstanding<=2"}, out_viol, 0);
  endtask

  initial begin
    int hs0, cycles;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.pt_ready = 1'b0;
    bus.dp_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) pts[i] = 16'h0010 + 16'(i);
    run_job(4, 2, 0, 1'b0, "basic");

    for (int i = 0; i < 8; i++) pts[i] = 16'($urandom);
    run_job(8, 1, 1, 1'b0, "backpressure");

    bad_word(16'h0000, "err_zero");
    bad_word(16'h1001, "err_4097");

    for (int i = 0; i < 1024; i++) pts[i] = 16'($urandom);
    run_job(1024, 512, 2, 1'b0, "n1024");

    for (int i = 0; i < 4096; i++) pts[i] = 16'($urandom);
    run_job(4096, 0, 0, 1'b0, "full");

    for (int i = 0; i < 16; i++) pts[i] = 16'($urandom);
    run_job(16, 3, 2, 1'b1, "ignored");

    for (int i = 0; i < 8; i++) pts[i] = 16'($urandom);
    load_job(8, 1, 1'b0, 1'b0);
    hs0 = got_data.size();
    cycles = 0;
    bus.pt_ready = 1'b1;
    while (got_data.size() - hs0 < 5 && cycles < 100) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("midrst delivered", got_data.size() - hs0, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("midrst");
    rst = 1'b0;
    bus.pt_ready = 1'b0;

    pts[0] = 16'hAAAA;
    pts[1] = 16'hBBBB;
    run_job(2, 1, 0, 1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
